// File: rtl/cpu_trace_emitter_if.sv
// Trace record input and character output bundle for cpu_trace_emitter.
// master = record producer / character sink side, slave = the emitter.
interface cpu_trace_emitter_if;
  // Both handshakes: a transfer happens on a rising clock edge where valid && ready are both 1;
  // the sender holds valid and its payload stable until that edge, and ready may change freely.
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  char;
  logic        char_valid;
  logic        char_ready;
  logic        time_ovf;

  modport master (
    output in_valid, in_kind, in_time, in_pc, in_reg, in_addr, in_data, char_ready,
    input  in_ready, char, char_valid, time_ovf
  );

  modport slave (
    input  in_valid, in_kind, in_time, in_pc, in_reg, in_addr, in_data, char_ready,
    output in_ready, char, char_valid, time_ovf
  );
endinterface

// File: rtl/cpu_trace_emitter.sv
// Serialises register/memory write trace records into an ASCII character stream,
// one character per transfer: ^T@PPPPPPPP:$R<=DDDDDDDD#  or  ^T@PPPPPPPP:*AAAAAAAA<=DDDDDDDD#
module cpu_trace_emitter (
  input  logic                      clk,
  input  logic                      reset,
  cpu_trace_emitter_if.slave        bus,
  output logic [3:0]                state_dbg
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CARET = 4'd1,
    TIME  = 4'd2,
    AT    = 4'd3,
    PC    = 4'd4,
    COLON = 4'd5,
    TAG   = 4'd6,
    INDEX = 4'd7,
    LT    = 4'd8,
    EQ    = 4'd9,
    DATA  = 4'd10,
    HASH  = 4'd11
  } state_t;

  state_t      state;
  logic [7:0]  char_q;
  logic        char_valid_q;
  logic        in_ready_q;
  logic        time_ovf_q;
  logic [2:0]  cnt;

  logic        kind_q;
  logic [15:0] t_bcd_q;
  logic [1:0]  t_first_q;
  logic [7:0]  r_bcd_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        xfer;
  logic        accept;
  logic [13:0] t_sat;
  logic [15:0] t_bcd;
  logic [7:0]  r_bcd;
  logic [1:0]  t_first;

  function automatic logic [7:0] dec_char(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? {4'h3, d} : (8'h57 + {4'h0, d});
  endfunction

  // idx 0 selects the most significant nibble
  function automatic logic [3:0] nib32(input logic [31:0] v, input logic [2:0] idx);
    return v[{~idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] nib16(input logic [15:0] v, input logic [1:0] idx);
    return v[{~idx, 2'b00} +: 4];
  endfunction

  assign xfer   = char_valid_q && bus.char_ready;
  assign accept = bus.in_valid && in_ready_q;

  // Decimal digits are prepared once at acceptance (double dabble) so emission only indexes them.
  always_comb begin
    t_sat = (bus.in_time > 14'd9999) ? 14'd9999 : bus.in_time;
    t_bcd = 16'h0000;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 4; j++) begin
        if (t_bcd[4*j +: 4] > 4'd4) t_bcd[4*j +: 4] = t_bcd[4*j +: 4] + 4'd3;
      end
      t_bcd = {t_bcd[14:0], t_sat[i]};
    end
    r_bcd = 8'h00;
    for (int i = 4; i >= 0; i--) begin
      for (int j = 0; j < 2; j++) begin
        if (r_bcd[4*j +: 4] > 4'd4) r_bcd[4*j +: 4] = r_bcd[4*j +: 4] + 4'd3;
      end
      r_bcd = {r_bcd[6:0], bus.in_reg[i]};
    end
    if (t_bcd[15:12] != 4'd0)     t_first = 2'd0;
    else if (t_bcd[11:8] != 4'd0) t_first = 2'd1;
    else if (t_bcd[7:4] != 4'd0)  t_first = 2'd2;
    else                          t_first = 2'd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      time_ovf_q   <= 1'b0;
      cnt          <= 3'd0;
      kind_q       <= 1'b0;
      t_bcd_q      <= 16'h0000;
      t_first_q    <= 2'd0;
      r_bcd_q      <= 8'h00;
      pc_q         <= 32'h0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            kind_q       <= bus.in_kind;
            t_bcd_q      <= t_bcd;
            t_first_q    <= t_first;
            r_bcd_q      <= r_bcd;
            pc_q         <= bus.in_pc;
            addr_q       <= bus.in_addr;
            data_q       <= bus.in_data;
            if (bus.in_time > 14'd9999) time_ovf_q <= 1'b1;
            state        <= CARET;
            char_q       <= 8'h5e;
            char_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
          end else begin
            in_ready_q   <= 1'b1;
          end
        end
        CARET: if (xfer) begin
          state  <= TIME;
          cnt    <= {1'b0, t_first_q};
          char_q <= dec_char(nib16(t_bcd_q, t_first_q));
        end
        TIME: if (xfer) begin
          if (cnt[1:0] == 2'd3) begin
            state  <= AT;
            char_q <= 8'h40;
          end else begin
            cnt    <= cnt + 3'd1;
            char_q <= dec_char(nib16(t_bcd_q, cnt[1:0] + 2'd1));
          end
        end
        AT: if (xfer) begin
          state  <= PC;
          cnt    <= 3'd0;
          char_q <= hex_char(pc_q[31:28]);
        end
        PC: if (xfer) begin
          if (cnt == 3'd7) begin
            state  <= COLON;
            char_q <= 8'h3a;
          end else begin
            cnt    <= cnt + 3'd1;
            char_q <= hex_char(nib32(pc_q, cnt + 3'd1));
          end
        end
        COLON: if (xfer) begin
          state  <= TAG;
          char_q <= kind_q ? 8'h2a : 8'h24;
        end
        TAG: if (xfer) begin
          state <= INDEX;
          if (kind_q) begin
            cnt    <= 3'd0;
            char_q <= hex_char(addr_q[31:28]);
          end else if (r_bcd_q[7:4] != 4'd0) begin
            cnt    <= 3'd0;
            char_q <= dec_char(r_bcd_q[7:4]);
          end else begin
            cnt    <= 3'd1;
            char_q <= dec_char(r_bcd_q[3:0]);
          end
        end
        // Register index ends at cnt 1 (ones digit); address index ends at cnt 7.
        INDEX: if (xfer) begin
          if ((kind_q && cnt == 3'd7) || (!kind_q && cnt == 3'd1)) begin
            state  <= LT;
            char_q <= 8'h3c;
          end else if (kind_q) begin
            cnt    <= cnt + 3'd1;
            char_q <= hex_char(nib32(addr_q, cnt + 3'd1));
          end else begin
            cnt    <= 3'd1;
            char_q <= dec_char(r_bcd_q[3:0]);
          end
        end
        LT: if (xfer) begin
          state  <= EQ;
          char_q <= 8'h3d;
        end
        EQ: if (xfer) begin
          state  <= DATA;
          cnt    <= 3'd0;
          char_q <= hex_char(data_q[31:28]);
        end
        DATA: if (xfer) begin
          if (cnt == 3'd7) begin
            state  <= HASH;
            char_q <= 8'h23;
          end else begin
            cnt    <= cnt + 3'd1;
            char_q <= hex_char(nib32(data_q, cnt + 3'd1));
          end
        end
        HASH: if (xfer) begin
          state        <= IDLE;
          char_q       <= 8'h00;
          char_valid_q <= 1'b0;
          in_ready_q   <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          char_q       <= 8'h00;
          char_valid_q <= 1'b0;
          in_ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.char       = char_q;
  assign bus.char_valid = char_valid_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.time_ovf   = time_ovf_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: table vectors, randomized records against a string-format
// reference model, backpressure hold checks and a mid-record reset abort.
module tb_cpu_trace_emitter;

  logic       clk;
  logic       reset;
  logic [3:0] state_dbg;

  cpu_trace_emitter_if bus ();

  cpu_trace_emitter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  logic [7:0] exp_q[$];
  logic model_ovf;

  typedef struct {
    logic        k;
    logic [13:0] t;
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] a;
    logic [31:0] d;
    string       s;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / monitor ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char  = 8'h00;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(bus.char_valid === 1'b1 && bus.char === prev_char)) begin
          errors++;
          $display("FAIL stall_hold actual valid=%0b char=%02h required valid=1 char=%02h",
                   bus.char_valid, bus.char, prev_char);
        end
      end
      if (bus.char_valid && bus.char_ready) begin
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_char actual=%02h required=no transfer", bus.char);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.char !== e) begin
            errors++;
            $display("FAIL char actual=%02h required=%02h", bus.char, e);
          end
        end
      end
      prev_stall = bus.char_valid && !bus.char_ready;
      prev_char  = bus.char;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic string model_str(input logic k, input logic [13:0] t, input logic [31:0] pc,
                                      input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
    int ts;
    ts = (t > 14'd9999) ? 9999 : int'(t);
    if (!k) return $sformatf("^%0d@%08h:$%0d<=%08h#", ts, pc, r, d);
    return $sformatf("^%0d@%08h:*%08h<=%08h#", ts, pc, a, d);
  endfunction

  // ---------------- drivers ----------------
  task automatic accept_rec(input logic k, input logic [13:0] t, input logic [31:0] pc,
                            input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                            input bit rnd);
    int budget;
    budget = 0;
    while (!bus.in_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_wait actual in_ready=0 required in_ready=1 within 200 cycles");
    end
    bus.in_kind    = k;
    bus.in_time    = t;
    bus.in_pc      = pc;
    bus.in_reg     = r;
    bus.in_addr    = a;
    bus.in_data    = d;
    bus.in_valid   = 1'b1;
    bus.char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_kind  = ~k;
    bus.in_time  = 14'($urandom());
    bus.in_pc    = $urandom();
    bus.in_reg   = 5'($urandom());
    bus.in_addr  = $urandom();
    bus.in_data  = $urandom();
    chk("first_valid", bus.char_valid, 1);
    chk("first_char", bus.char, 8'h5e);
  endtask

  task automatic run_record(input logic k, input logic [13:0] t, input logic [31:0] pc,
                            input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                            input string s, input bit rnd, input bit junk);
    int run;
    int budget;
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    accept_rec(k, t, pc, r, a, d, rnd);
    run = 0;
    budget = 0;
    while (!(bus.in_ready && exp_q.size() == 0) && budget < 2000) begin
      if (bus.char_valid) run++;
      if (rnd) bus.char_ready = 1'($urandom_range(0, 1));
      if (junk && !bus.in_ready) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_pc    = $urandom();
        bus.in_time  = 14'($urandom());
        bus.in_kind  = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      budget++;
    end
    bus.in_valid   = 1'b0;
    bus.char_ready = 1'b1;
    if (budget >= 2000) begin
      checks++;
      errors++;
      $display("FAIL record_timeout actual pending=%0d required pending=0 within 2000 cycles", exp_q.size());
      exp_q.delete();
    end
    if (!rnd) chk("valid_run", run, s.len());
    chk("gap_ready", bus.in_ready, 1);
    chk("gap_valid", bus.char_valid, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int base;
    int budget;
    logic        k;
    logic [13:0] t;
    logic [31:0] pc, a, d;
    logic [4:0]  r;

    vecs[0] = '{1'b0, 14'd1024,  32'h00003000, 5'd2,  32'h0,        32'h89abcdef, "^1024@00003000:$2<=89abcdef#", 1'b0};
    vecs[1] = '{1'b1, 14'd0,     32'hdeadbeef, 5'd0,  32'h0000001c, 32'h00000000, "^0@deadbeef:*0000001c<=00000000#", 1'b0};
    vecs[2] = '{1'b0, 14'd9999,  32'h0000ffff, 5'd10, 32'h0,        32'h0000a0a0, "^9999@0000ffff:$10<=0000a0a0#", 1'b0};
    vecs[3] = '{1'b1, 14'd10,    32'h00000001, 5'd0,  32'hfedcba98, 32'h00000001, "^10@00000001:*fedcba98<=00000001#", 1'b0};
    vecs[4] = '{1'b0, 14'd16383, 32'h00000040, 5'd31, 32'h0,        32'h12345678, "^9999@00000040:$31<=12345678#", 1'b1};
    vecs[5] = '{1'b0, 14'd5,     32'h00000000, 5'd0,  32'h0,        32'hffffffff, "^5@00000000:$0<=ffffffff#", 1'b1};
    vecs[6] = '{1'b1, 14'd10000, 32'h80000000, 5'd7,  32'h00000000, 32'h00000007, "^9999@80000000:*00000000<=00000007#", 1'b1};

    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_kind    = 1'b0;
    bus.in_time    = '0;
    bus.in_pc      = '0;
    bus.in_reg     = '0;
    bus.in_addr    = '0;
    bus.in_data    = '0;
    bus.char_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_char_valid", bus.char_valid, 0);
    chk("rst_char", bus.char, 8'h00);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_time_ovf", bus.time_ovf, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_valid", bus.char_valid, 0);

    // Directed table, char_ready held high
    for (int i = 0; i < 7; i++) begin
      run_record(vecs[i].k, vecs[i].t, vecs[i].pc, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].s, 1'b0, 1'b0);
      chk($sformatf("table%0d_ovf", i), bus.time_ovf, vecs[i].ovf);
    end
    model_ovf = 1'b1;

    // Backpressure with ignored in_valid pulses during emission
    run_record(vecs[0].k, vecs[0].t, vecs[0].pc, vecs[0].r, vecs[0].a, vecs[0].d, vecs[0].s, 1'b1, 1'b1);

    // Mid-record reset: abort after the 10th transfer
    for (int i = 0; i < vecs[0].s.len(); i++) exp_q.push_back(vecs[0].s[i]);
    accept_rec(vecs[0].k, vecs[0].t, vecs[0].pc, vecs[0].r, vecs[0].a, vecs[0].d, 1'b0);
    base = xfer_cnt - 0;
    budget = 0;
    while (xfer_cnt < base + 10 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("abort_xfers", xfer_cnt - base, 10);
    reset = 1'b0;
    #1;
    chk("abort_valid", bus.char_valid, 0);
    chk("abort_ready", bus.in_ready, 0);
    chk("abort_ovf", bus.time_ovf, 0);
    chk("abort_state", state_dbg, 0);
    exp_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_rel_ready", bus.in_ready, 1);
    chk("abort_rel_valid", bus.char_valid, 0);
    run_record(vecs[0].k, vecs[0].t, vecs[0].pc, vecs[0].r, vecs[0].a, vecs[0].d, vecs[0].s, 1'b0, 1'b0);
    chk("abort_after_ovf", bus.time_ovf, 0);

    // Randomized records against the reference model
    for (int n = 0; n < 24; n++) begin
      k  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       t = 14'($urandom_range(0, 12));
        1:       t = 14'($urandom_range(0, 9999));
        2:       t = 14'($urandom_range(9990, 10010));
        default: t = 14'($urandom_range(0, 16383));
      endcase
      pc = $urandom();
      r  = 5'($urandom_range(0, 31));
      a  = $urandom();
      d  = $urandom();
      run_record(k, t, pc, r, a, d, model_str(k, t, pc, r, a, d),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_ovf = model_ovf | (t > 14'd9999);
      chk("rand_ovf", bus.time_ovf, model_ovf);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_trace_emitter.md
CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port in_valid, input, 1 bit: a trace record is presented on the in_* ports.
REQ-004 SHALL have port in_ready, output, 1 bit: emitter accepts a record this cycle.
REQ-005 SHALL have port in_kind, input, 1 bit: 0 = register write, 1 = memory write.
REQ-006 SHALL have port in_time, input, 14 bits: unsigned timestamp.
REQ-007 SHALL have port in_pc, input, 32 bits: instruction address.
REQ-008 SHALL have port in_reg, input, 5 bits: register number (kind 0).
REQ-009 SHALL have port in_addr, input, 32 bits: memory address (kind 1).
REQ-010 SHALL have port in_data, input, 32 bits: written value.
REQ-011 SHALL have port char, output, 8 bits: ASCII character.
REQ-012 SHALL have port char_valid, output, 1 bit: char is valid.
REQ-013 SHALL have port char_ready, input, 1 bit: sink consumes char this cycle.
REQ-014 SHALL have port time_ovf, output, 1 bit: sticky flag, set when a time above 9999 was saturated.

Function
REQ-015 SHALL serialize each accepted record, one character per transfer, with no spaces.
- Kind 0 format: ^T@PPPPPPPP:$R<=DDDDDDDD#
- Kind 1 format: ^T@PPPPPPPP:*AAAAAAAA<=DDDDDDDD#
REQ-016 SHALL emit T as 1 to 4 decimal digits, most significant first, with no leading zeros; time 0 SHALL print as "0".
REQ-017 SHALL saturate in_time values above 9999 to 9999 and set time_ovf.
REQ-018 SHALL emit R as 1 to 2 decimal digits (0 to 31) with no leading zeros.
REQ-019 SHALL emit P, A and D as exactly 8 hex digits, most significant nibble first, using lowercase a to f.
REQ-020 SHALL use the FSM states IDLE, CARET, TIME, AT, PC, COLON, TAG, INDEX, LT, EQ, DATA and HASH.
- Each state SHALL advance, or step its digit counter, only on a transfer, where a transfer is char_valid && char_ready.
- HASH SHALL go to IDLE on its transfer.
REQ-021 SHALL drive in_ready = 1 only in IDLE; a record is accepted when in_valid && in_ready at a clock edge.
REQ-022 SHALL latch all in_* fields on acceptance; later changes to in_* SHALL NOT affect the record in flight.
REQ-023 SHALL assert char_valid with char = '^' on the cycle after acceptance (latency 1).
REQ-024 SHALL hold char_valid asserted, with no gaps, from '^' through '#' when char_ready is held at 1.
REQ-025 SHALL hold char and char_valid stable while char_valid && !char_ready (backpressure), for any number of cycles.
REQ-026 SHALL drive char_valid = 0 in IDLE; the cycle after the '#' transfer SHALL be IDLE with in_ready = 1, giving a minimum record gap of 1 cycle.
REQ-027 SHALL ignore in_valid while not in IDLE; no record is queued.
REQ-028 SHALL keep time_ovf set until reset; it SHALL NOT be cleared by later records.

Reset
REQ-029 SHALL, while reset = 0, asynchronously force:
- state = IDLE
- char_valid = 0
- char = 8'h00
- in_ready = 0
- time_ovf = 0
- all latched fields = 0
REQ-030 SHALL drive in_ready = 1 on the first clock edge after reset rises, with no record pending.
REQ-031 SHALL abort any record in flight when reset is asserted mid-record; no further characters of it SHALL be emitted after reset is released.

Verification
REQ-032 Kind 0, time 1024, pc 0x00003000, reg 2, data 0x89abcdef, char_ready = 1 -> exactly "^1024@00003000:$2<=89abcdef#", 28 consecutive valid cycles, first char 1 cycle after accept.
REQ-033 Kind 1, time 0, pc 0xdeadbeef, addr 0x0000001c, data 0x0, char_ready = 1 -> "^0@deadbeef:*0000001c<=00000000#" (32 chars).
REQ-034 Kind 0, time 16383, reg 31 -> time printed as "9999", register printed as "31", time_ovf = 1 and still 1 after a following record with time 5.
REQ-035 Record of REQ-032 with char_ready toggling pseudo-randomly -> the same 28-character string with no char change while stalled; in_valid pulses with other data during emission are ignored.
REQ-036 Reset driven low after the 10th transfer of a record -> char_valid = 0 immediately; after release, in_ready = 1 and the next record emits from '^' correctly.
